// File: rtl/mcl_host_pkt_gearbox.sv
// Width gearbox between 32-bit host words and 128-bit manycore-link packets, with request credit gating.
// Optional packet counters are built when MCL_GEARBOX_PKT_COUNT_EN is defined.
module mcl_host_pkt_gearbox #(
   parameter  int word_width_p = 32,
   parameter  int pkt_width_p  = 128,
   parameter  int credits_p    = 32,
   localparam int credit_w_lp  = $clog2(credits_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   // request path: host words in, packets out
   input  logic                    req_word_v_i,
   input  logic [word_width_p-1:0] req_word_i,
   output logic                    req_word_ready_o,
   output logic                    req_pkt_v_o,
   output logic [pkt_width_p-1:0]  req_pkt_o,
   input  logic                    req_pkt_ready_i,
   // credit bookkeeping
   input  logic                    credit_return_i,
   output logic [credit_w_lp-1:0]  credits_o,
   output logic                    credit_overflow_o,
   // response path: packets in, host words out
   input  logic                    rsp_pkt_v_i,
   input  logic [pkt_width_p-1:0]  rsp_pkt_i,
   output logic                    rsp_pkt_ready_o,
   output logic                    rsp_word_v_o,
   output logic [word_width_p-1:0] rsp_word_o,
   input  logic                    rsp_word_ready_i,
   // packet counters
   output logic [31:0]             req_pkt_count_o,
   output logic [31:0]             rsp_pkt_count_o
);

   localparam int                     words_lp       = pkt_width_p / word_width_p;
   localparam int                     idx_w_lp       = $clog2(words_lp);
   localparam logic [idx_w_lp-1:0]    last_idx_lp    = idx_w_lp'(words_lp - 1);
   localparam logic [credit_w_lp-1:0] credits_max_lp = credit_w_lp'(credits_p);
   localparam int                     rest_w_lp      = pkt_width_p - word_width_p;

   typedef enum logic {REQ_ASSEMBLE, REQ_FULL} req_state_e;
   typedef enum logic {RSP_IDLE, RSP_SEND} rsp_state_e;

   // ---------------------------------------------------------------- request path
   req_state_e                r_req_state, w_req_state_nxt;
   logic [idx_w_lp-1:0]       r_req_idx, w_req_idx_nxt;
   logic                      r_req_word_ready;
   logic [pkt_width_p-1:0]    r_req_pkt;
   logic [credit_w_lp-1:0]    r_credits, w_credits_nxt;
   logic                      r_credit_overflow, w_overflow_set;
   logic                      w_req_word_hs, w_req_pkt_hs, w_req_pkt_v;

   assign w_req_word_hs = req_word_v_i & r_req_word_ready;
   // The credit gate is the only combinational output path.
   assign w_req_pkt_v   = (r_req_state == REQ_FULL) && (r_credits != '0);
   assign w_req_pkt_hs  = w_req_pkt_v & req_pkt_ready_i;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      w_req_state_nxt = r_req_state;
      w_req_idx_nxt   = r_req_idx;
      unique case (r_req_state)
         REQ_ASSEMBLE: begin
            if (w_req_word_hs) begin
               w_req_idx_nxt = r_req_idx + idx_w_lp'(1);
               if (r_req_idx == last_idx_lp) w_req_state_nxt = REQ_FULL;
            end
         end
         REQ_FULL: begin
            if (w_req_pkt_hs) begin
               w_req_state_nxt = REQ_ASSEMBLE;
               w_req_idx_nxt   = '0;
            end
         end
         default: begin
            w_req_state_nxt = REQ_ASSEMBLE;
            w_req_idx_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_req_state      <= REQ_ASSEMBLE;
         r_req_idx        <= '0;
         r_req_word_ready <= 1'b1;
      end else begin
         r_req_state      <= w_req_state_nxt;
         r_req_idx        <= w_req_idx_nxt;
         r_req_word_ready <= (w_req_state_nxt == REQ_ASSEMBLE);
      end
   end

   // NOTE: the packet register is reset (not left as don't-care) because req_pkt_o has a defined reset value.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_req_pkt <= '0;
      end else if (w_req_word_hs) begin
         for (int i = 0; i < words_lp; i++) begin
            if (r_req_idx == idx_w_lp'(i)) r_req_pkt[i*word_width_p +: word_width_p] <= req_word_i;
         end
      end
   end

   always_comb begin
      w_credits_nxt  = r_credits;
      w_overflow_set = 1'b0;
      unique case ({w_req_pkt_hs, credit_return_i})
         2'b10: w_credits_nxt = r_credits - credit_w_lp'(1);
         2'b01: begin
            if (r_credits == credits_max_lp) w_overflow_set = 1'b1;
            else                             w_credits_nxt  = r_credits + credit_w_lp'(1);
         end
         default: w_credits_nxt = r_credits;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_credits         <= credits_max_lp;
         r_credit_overflow <= 1'b0;
      end else begin
         r_credits         <= w_credits_nxt;
         r_credit_overflow <= r_credit_overflow | w_overflow_set;
      end
   end

   assign req_word_ready_o  = r_req_word_ready;
   assign req_pkt_v_o       = w_req_pkt_v;
   assign req_pkt_o         = r_req_pkt;
   assign credits_o         = r_credits;
   assign credit_overflow_o = r_credit_overflow;

   // --------------------------------------------------------------- response path
   rsp_state_e                r_rsp_state, w_rsp_state_nxt;
   logic [idx_w_lp-1:0]       r_rsp_idx, w_rsp_idx_nxt;
   logic                      r_rsp_pkt_ready, r_rsp_word_v;
   logic [word_width_p-1:0]   r_rsp_word;
   logic [rest_w_lp-1:0]      r_rsp_rest;
   logic                      w_rsp_pkt_hs, w_rsp_word_hs;

   assign w_rsp_pkt_hs  = rsp_pkt_v_i & r_rsp_pkt_ready;
   assign w_rsp_word_hs = r_rsp_word_v & rsp_word_ready_i;

   always_comb begin
      w_rsp_state_nxt = r_rsp_state;
      w_rsp_idx_nxt   = r_rsp_idx;
      unique case (r_rsp_state)
         RSP_IDLE: begin
            if (w_rsp_pkt_hs) begin
               w_rsp_state_nxt = RSP_SEND;
               w_rsp_idx_nxt   = '0;
            end
         end
         RSP_SEND: begin
            if (w_rsp_word_hs) begin
               w_rsp_idx_nxt = r_rsp_idx + idx_w_lp'(1);
               if (r_rsp_idx == last_idx_lp) w_rsp_state_nxt = RSP_IDLE;
            end
         end
         default: begin
            w_rsp_state_nxt = RSP_IDLE;
            w_rsp_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rsp_state     <= RSP_IDLE;
         r_rsp_idx       <= '0;
         r_rsp_pkt_ready <= 1'b1;
         r_rsp_word_v    <= 1'b0;
      end else begin
         r_rsp_state     <= w_rsp_state_nxt;
         r_rsp_idx       <= w_rsp_idx_nxt;
         r_rsp_pkt_ready <= (w_rsp_state_nxt == RSP_IDLE);
         r_rsp_word_v    <= (w_rsp_state_nxt == RSP_SEND);
      end
   end

   // Word 0 goes straight to the output register; the remaining words shift down behind it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rsp_word <= '0;
         r_rsp_rest <= '0;
      end else if (w_rsp_pkt_hs) begin
         r_rsp_word <= rsp_pkt_i[word_width_p-1:0];
         r_rsp_rest <= rsp_pkt_i[pkt_width_p-1:word_width_p];
      end else if (w_rsp_word_hs && (r_rsp_idx != last_idx_lp)) begin
         r_rsp_word <= r_rsp_rest[word_width_p-1:0];
         r_rsp_rest <= {{word_width_p{1'b0}}, r_rsp_rest[rest_w_lp-1:word_width_p]};
      end
   end

   assign rsp_pkt_ready_o = r_rsp_pkt_ready;
   assign rsp_word_v_o    = r_rsp_word_v;
   assign rsp_word_o      = r_rsp_word;

   // ------------------------------------------------------------- packet counters
`ifdef MCL_GEARBOX_PKT_COUNT_EN
   logic [31:0] r_req_pkt_count, r_rsp_pkt_count;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_req_pkt_count <= '0;
         r_rsp_pkt_count <= '0;
      end else begin
         if (w_req_pkt_hs) r_req_pkt_count <= r_req_pkt_count + 32'd1;
         if (w_rsp_pkt_hs) r_rsp_pkt_count <= r_rsp_pkt_count + 32'd1;
      end
   end

   assign req_pkt_count_o = r_req_pkt_count;
   assign rsp_pkt_count_o = r_rsp_pkt_count;
`else
   assign req_pkt_count_o = '0;
   assign rsp_pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_mcl_host_pkt_gearbox.sv
// Self-checking bench for mcl_host_pkt_gearbox: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mcl_host_pkt_gearbox;

   localparam int CREDITS = 32;
   localparam int CW      = $clog2(CREDITS + 1);
`ifdef MCL_GEARBOX_PKT_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic           clk_i, reset_n_i;
   logic           req_word_v_i, req_word_ready_o, req_pkt_v_o, req_pkt_ready_i;
   logic [31:0]    req_word_i;
   logic [127:0]   req_pkt_o;
   logic           credit_return_i, credit_overflow_o;
   logic [CW-1:0]  credits_o;
   logic           rsp_pkt_v_i, rsp_pkt_ready_o, rsp_word_v_o, rsp_word_ready_i;
   logic [127:0]   rsp_pkt_i;
   logic [31:0]    rsp_word_o, req_pkt_count_o, rsp_pkt_count_o;

   mcl_host_pkt_gearbox #(.word_width_p(32), .pkt_width_p(128), .credits_p(CREDITS)) u_dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .req_word_v_i(req_word_v_i), .req_word_i(req_word_i), .req_word_ready_o(req_word_ready_o),
      .req_pkt_v_o(req_pkt_v_o), .req_pkt_o(req_pkt_o), .req_pkt_ready_i(req_pkt_ready_i),
      .credit_return_i(credit_return_i), .credits_o(credits_o), .credit_overflow_o(credit_overflow_o),
      .rsp_pkt_v_i(rsp_pkt_v_i), .rsp_pkt_i(rsp_pkt_i), .rsp_pkt_ready_o(rsp_pkt_ready_o),
      .rsp_word_v_o(rsp_word_v_o), .rsp_word_o(rsp_word_o), .rsp_word_ready_i(rsp_word_ready_i),
      .req_pkt_count_o(req_pkt_count_o), .rsp_pkt_count_o(rsp_pkt_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: words collected so far, words still owed to the host, credit count.
   logic [31:0] m_req_q[$];
   logic [31:0] m_rsp_q[$];
   int          m_credits;
   bit          m_ovf;
   logic [31:0] m_req_cnt, m_rsp_cnt;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_req_q.delete();
      m_rsp_q.delete();
      m_credits = CREDITS;
      m_ovf     = 1'b0;
      m_req_cnt = '0;
      m_rsp_cnt = '0;
   endtask

   task automatic check_model();
      bit full;
      full = (m_req_q.size() == 4);
      check("req_word_ready", req_word_ready_o, !full);
      check("req_pkt_v", req_pkt_v_o, full && (m_credits != 0));
      if (full) check("req_pkt", req_pkt_o, {m_req_q[3], m_req_q[2], m_req_q[1], m_req_q[0]});
      check("credits", credits_o, m_credits);
      check("credit_overflow", credit_overflow_o, m_ovf);
      check("rsp_pkt_ready", rsp_pkt_ready_o, m_rsp_q.size() == 0);
      check("rsp_word_v", rsp_word_v_o, m_rsp_q.size() != 0);
      if (m_rsp_q.size() != 0) check("rsp_word", rsp_word_o, m_rsp_q[0]);
      check("req_pkt_count", req_pkt_count_o, CNT_EN ? m_req_cnt : 32'd0);
      check("rsp_pkt_count", rsp_pkt_count_o, CNT_EN ? m_rsp_cnt : 32'd0);
   endtask

   // One clock: predict handshakes from the model, advance the model, then compare 1 ns after the edge.
   task automatic tick();
      bit hs_w, hs_p, hs_rp, hs_rw;
      hs_w  = req_word_v_i && (m_req_q.size() < 4);
      hs_p  = (m_req_q.size() == 4) && (m_credits != 0) && req_pkt_ready_i;
      hs_rp = rsp_pkt_v_i && (m_rsp_q.size() == 0);
      hs_rw = (m_rsp_q.size() != 0) && rsp_word_ready_i;
      @(posedge clk_i);
      if (hs_p) begin
         m_req_q.delete();
         m_req_cnt = m_req_cnt + 32'd1;
      end
      if (hs_w) m_req_q.push_back(req_word_i);
      if (hs_p && !credit_return_i) m_credits--;
      else if (credit_return_i && !hs_p) begin
         if (m_credits == CREDITS) m_ovf = 1'b1;
         else                      m_credits++;
      end
      if (hs_rw) void'(m_rsp_q.pop_front());
      if (hs_rp) begin
         m_rsp_cnt = m_rsp_cnt + 32'd1;
         for (int i = 0; i < 4; i++) m_rsp_q.push_back(rsp_pkt_i[32*i +: 32]);
      end
      #1;
      check_model();
   endtask

   task automatic idle_inputs();
      req_word_v_i = 0; req_word_i = '0; req_pkt_ready_i = 0; credit_return_i = 0;
      rsp_pkt_v_i = 0; rsp_pkt_i = '0; rsp_word_ready_i = 0;
   endtask

   // Asserts reset between clock edges and checks outputs before any edge arrives.
   task automatic do_reset();
      idle_inputs();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      #1;
      check("rst_req_word_ready", req_word_ready_o, 1'b1);
      check("rst_req_pkt_v", req_pkt_v_o, 1'b0);
      check("rst_req_pkt", req_pkt_o, 128'h0);
      check("rst_credits", credits_o, CREDITS);
      check("rst_overflow", credit_overflow_o, 1'b0);
      check("rst_rsp_pkt_ready", rsp_pkt_ready_o, 1'b1);
      check("rst_rsp_word_v", rsp_word_v_o, 1'b0);
      check("rst_rsp_word", rsp_word_o, 32'h0);
      check("rst_req_count", req_pkt_count_o, 32'h0);
      check("rst_rsp_count", rsp_pkt_count_o, 32'h0);
      model_reset();
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   task automatic load_pkt();
      for (int i = 0; i < 4; i++) begin
         req_word_v_i = 1'b1;
         req_word_i   = $urandom;
         tick();
      end
      req_word_v_i = 1'b0;
   endtask

   task automatic xfer();
      req_pkt_ready_i = 1'b1;
      tick();
      req_pkt_ready_i = 1'b0;
   endtask

   typedef struct {
      logic         req_v;
      logic [31:0]  req_w;
      logic         pkt_rdy;
      logic         rsp_v;
      logic [127:0] rsp_p;
      logic         w_rdy;
      logic         e_wr;
      logic         e_pv;
      logic [127:0] e_pkt;
      logic [CW-1:0] e_cr;
      logic         e_prdy;
      logic         e_wv;
      logic [31:0]  e_word;
   } vec_t;

   function automatic vec_t req_row(logic v, logic [31:0] w, logic e_wr, logic e_pv, logic [127:0] e_pkt,
                                    logic [CW-1:0] e_cr);
      vec_t r;
      r = '{v, w, 1'b1, 1'b0, 128'h0, 1'b0, e_wr, e_pv, e_pkt, e_cr, 1'b1, 1'b0, 32'h0};
      return r;
   endfunction

   function automatic vec_t rsp_row(logic v, logic [127:0] p, logic rdy, logic e_prdy, logic e_wv,
                                    logic [31:0] e_word);
      vec_t r;
      r = '{1'b0, 32'h0, 1'b0, v, p, rdy, 1'b1, 1'b0, 128'h0, CW'(31), e_prdy, e_wv, e_word};
      return r;
   endfunction

   vec_t vecs[12];

   initial begin
      logic [127:0] rsp_pat, pkt1;
      rsp_pat = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      pkt1    = 128'h44444444_33333333_22222222_11111111;
      vecs[0]  = req_row(1'b1, 32'h11111111, 1'b1, 1'b0, 128'h0, CW'(32));
      vecs[1]  = req_row(1'b1, 32'h22222222, 1'b1, 1'b0, 128'h0, CW'(32));
      vecs[2]  = req_row(1'b1, 32'h33333333, 1'b1, 1'b0, 128'h0, CW'(32));
      vecs[3]  = req_row(1'b1, 32'h44444444, 1'b0, 1'b1, pkt1,   CW'(32));
      vecs[4]  = req_row(1'b0, 32'h0,        1'b1, 1'b0, 128'h0, CW'(31));
      vecs[5]  = req_row(1'b0, 32'h0,        1'b1, 1'b0, 128'h0, CW'(31));
      vecs[6]  = rsp_row(1'b1, rsp_pat, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA);
      vecs[7]  = rsp_row(1'b0, 128'h0,  1'b1, 1'b0, 1'b1, 32'hBBBBBBBB);
      vecs[8]  = rsp_row(1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 32'hBBBBBBBB);
      vecs[9]  = rsp_row(1'b0, 128'h0,  1'b1, 1'b0, 1'b1, 32'hCCCCCCCC);
      vecs[10] = rsp_row(1'b0, 128'h0,  1'b1, 1'b0, 1'b1, 32'hDDDDDDDD);
      vecs[11] = rsp_row(1'b0, 128'h0,  1'b1, 1'b1, 1'b0, 32'h0);

      reset_n_i = 1'b0;
      idle_inputs();
      model_reset();
      do_reset();

      // Directed table: one request packet, then one response packet with a stalled host.
      foreach (vecs[k]) begin
         req_word_v_i = vecs[k].req_v;  req_word_i = vecs[k].req_w;  req_pkt_ready_i = vecs[k].pkt_rdy;
         rsp_pkt_v_i  = vecs[k].rsp_v;  rsp_pkt_i  = vecs[k].rsp_p;  rsp_word_ready_i = vecs[k].w_rdy;
         tick();
         check($sformatf("vec%0d_word_ready", k), req_word_ready_o, vecs[k].e_wr);
         check($sformatf("vec%0d_pkt_v", k), req_pkt_v_o, vecs[k].e_pv);
         if (vecs[k].e_pv) check($sformatf("vec%0d_pkt", k), req_pkt_o, vecs[k].e_pkt);
         check($sformatf("vec%0d_credits", k), credits_o, vecs[k].e_cr);
         check($sformatf("vec%0d_rsp_pkt_ready", k), rsp_pkt_ready_o, vecs[k].e_prdy);
         check($sformatf("vec%0d_rsp_word_v", k), rsp_word_v_o, vecs[k].e_wv);
         if (vecs[k].e_wv) check($sformatf("vec%0d_rsp_word", k), rsp_word_o, vecs[k].e_word);
      end
      idle_inputs();

      // Credit exhaustion: 32 packets drain the counter, the 33rd is held until a return.
      do_reset();
      for (int p = 0; p < CREDITS; p++) begin
         load_pkt();
         xfer();
      end
      check("credits_drained", credits_o, 0);
      load_pkt();
      req_pkt_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("held_pkt_v", req_pkt_v_o, 1'b0);
         check("held_word_ready", req_word_ready_o, 1'b0);
      end
      credit_return_i = 1'b1;
      tick();
      credit_return_i = 1'b0;
      check("release_pkt_v", req_pkt_v_o, 1'b1);
      check("release_credits", credits_o, 1);
      tick();
      check("release_sent_credits", credits_o, 0);
      req_pkt_ready_i = 1'b0;

      // Simultaneous send and return, then saturation at the maximum.
      credit_return_i = 1'b1;
      for (int c = 0; c < CREDITS - 1; c++) tick();
      credit_return_i = 1'b0;
      check("credits_31", credits_o, 31);
      load_pkt();
      req_pkt_ready_i = 1'b1;
      credit_return_i = 1'b1;
      tick();
      req_pkt_ready_i = 1'b0;
      check("send_and_return", credits_o, 31);
      tick();
      check("credits_full", credits_o, 32);
      check("no_overflow_yet", credit_overflow_o, 1'b0);
      tick();
      credit_return_i = 1'b0;
      check("credits_saturated", credits_o, 32);
      check("overflow_set", credit_overflow_o, 1'b1);
      tick();
      check("overflow_sticky", credit_overflow_o, 1'b1);

      // Reset in the middle of both paths, then a clean packet and no stray response words.
      req_word_v_i = 1'b1; req_word_i = 32'h0BAD0000;
      rsp_pkt_v_i  = 1'b1; rsp_pkt_i  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      req_word_i = 32'h0BAD0001;
      rsp_pkt_v_i = 1'b0; rsp_word_ready_i = 1'b1;
      tick();
      rsp_word_ready_i = 1'b0;
      do_reset();
      rsp_word_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_word_v_i = 1'b1;
         req_word_i   = 32'h5A000000 + i;
         tick();
         check("post_reset_rsp_quiet", rsp_word_v_o, 1'b0);
      end
      req_word_v_i = 1'b0;
      check("clean_pkt_v", req_pkt_v_o, 1'b1);
      check("clean_pkt", req_pkt_o, 128'h5A000003_5A000002_5A000001_5A000000);
      xfer();
      rsp_word_ready_i = 1'b0;

      // Counter wrap (counters read zero when they are not built).
`ifdef MCL_GEARBOX_PKT_COUNT_EN
      force u_dut.r_req_pkt_count = 32'hFFFF_FFFF;
      #1 release u_dut.r_req_pkt_count;
      m_req_cnt = 32'hFFFF_FFFF;
`endif
      load_pkt();
      xfer();
      check("req_count_wrap", req_pkt_count_o, 32'h0);

      // Randomized traffic: sparse returns first (reach zero credits), then frequent returns.
      for (int c = 0; c < 3000; c++) begin
         req_word_v_i     = ($urandom_range(0, 3) != 0);
         req_word_i       = $urandom;
         req_pkt_ready_i  = ($urandom_range(0, 3) != 0);
         credit_return_i  = (c < 1500) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) < 3);
         rsp_pkt_v_i      = $urandom_range(0, 1);
         rsp_pkt_i        = {$urandom, $urandom, $urandom, $urandom};
         rsp_word_ready_i = ($urandom_range(0, 4) < 3);
         tick();
      end
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
